// File: rtl/l1_trigger_pkg.sv
// Shared types for the L1 trigger chain: event record, acceptance FSM states, widths.
package l1_trigger_pkg;

  localparam int unsigned TAG_W    = 16;
  localparam int unsigned SAMPLE_W = 8;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [SAMPLE_W-1:0] energy;
    logic [SAMPLE_W-1:0] isol;
  } l1_event_t;

  typedef enum logic {
    IDLE = 1'b0,
    DEAD = 1'b1
  } l1_state_e;

endpackage

// File: rtl/l1_event_fifo.sv
// Synchronous FIFO of accepted L1 events; head is read combinationally from storage.
module l1_event_fifo
  import l1_trigger_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push,
  input  l1_event_t i_data,
  input  logic      i_pop,
  output l1_event_t o_head_c,
  output logic      o_full_c,
  output logic      o_empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  l1_event_t   r_mem [DEPTH];

  // Storage is cleared on reset so the head reads zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
      end
      if (i_pop && !o_empty_c) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

  assign o_head_c  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty_c = (r_wr_ptr == r_rd_ptr);
  assign o_full_c  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/l1_accept_buffer.sv
// L1 accept stage: dead-time, prescale, event tagging and drop counting in front of an event FIFO.
module l1_accept_buffer
  import l1_trigger_pkg::*;
#(
  parameter int unsigned DEADTIME = 4,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trigger,
  input  logic [SAMPLE_W-1:0] energy,
  input  logic [SAMPLE_W-1:0] isol,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [TAG_W-1:0]    out_tag,
  output logic [SAMPLE_W-1:0] out_energy,
  output logic [SAMPLE_W-1:0] out_isol,
  output logic                busy,
  output logic [TAG_W-1:0]    drop_count
);

  localparam int unsigned DC_W = (DEADTIME > 1) ? $clog2(DEADTIME + 1) : 1;
  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  l1_state_e        r_state;
  l1_state_e        w_state_nxt;
  logic [DC_W-1:0]  r_dead_cnt;
  logic [DC_W-1:0]  w_dead_nxt;
  logic [PS_W-1:0]  r_ps_cnt;
  logic [PS_W-1:0]  w_ps_nxt;
  logic [TAG_W-1:0] r_tag_cnt;
  logic [TAG_W-1:0] r_drop_cnt;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  l1_event_t        w_head;
  l1_event_t        w_wr_event;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_dead_cnt <= '0;
      r_ps_cnt   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_dead_cnt <= w_dead_nxt;
      r_ps_cnt   <= w_ps_nxt;
    end
  end

  // Dead-time runs until the counter reads 1; eligible triggers feed the prescaler.
  always_comb begin
    w_state_nxt = r_state;
    w_dead_nxt  = r_dead_cnt;
    w_ps_nxt    = r_ps_cnt;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (trigger) begin
          if (r_ps_cnt == PS_W'(PRESCALE - 1)) begin
            w_accept = 1'b1;
            w_ps_nxt = '0;
            if (DEADTIME > 0) begin
              w_state_nxt = DEAD;
              w_dead_nxt  = DC_W'(DEADTIME);
            end
          end else begin
            w_ps_nxt = r_ps_cnt + PS_W'(1);
          end
        end
      end
      DEAD: begin
        if (r_dead_cnt == DC_W'(1)) begin
          w_state_nxt = IDLE;
          w_dead_nxt  = '0;
        end else begin
          w_dead_nxt = r_dead_cnt - DC_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A pop frees the slot in the same edge, so a full FIFO can still take the write.
  assign w_pop  = out_valid && out_ready;
  assign w_push = w_accept && (!w_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_cnt  <= '0;
      r_drop_cnt <= '0;
    end else if (w_accept) begin
      r_tag_cnt <= r_tag_cnt + TAG_W'(1);
      if (!w_push && (r_drop_cnt != {TAG_W{1'b1}})) begin
        r_drop_cnt <= r_drop_cnt + TAG_W'(1);
      end
    end
  end

  assign w_wr_event = '{tag: r_tag_cnt, energy: energy, isol: isol};

  l1_event_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_data    (w_wr_event),
    .i_pop     (w_pop),
    .o_head_c  (w_head),
    .o_full_c  (w_full),
    .o_empty_c (w_empty)
  );

  assign out_valid  = !w_empty;
  assign out_tag    = w_head.tag;
  assign out_energy = w_head.energy;
  assign out_isol   = w_head.isol;
  assign busy       = (r_state == DEAD);
  assign drop_count = r_drop_cnt;

endmodule

// File: tb/tb_l1_accept_buffer.sv
// Randomized bench: three parameterizations driven in lockstep against a queue-based reference model.
module tb_l1_accept_buffer;

  localparam int NDUT  = 3;
  localparam int DEPTH = 8;

  logic       clk;
  logic       rst;
  logic       trigger;
  logic [7:0] energy;
  logic [7:0] isol;
  logic       out_ready;

  logic [NDUT-1:0] ov;
  logic [NDUT-1:0] bsy;
  logic [15:0]     otag [NDUT];
  logic [7:0]      oen  [NDUT];
  logic [7:0]      oiso [NDUT];
  logic [15:0]     odrop[NDUT];

  int dt_of[NDUT] = '{4, 0, 0};
  int ps_of[NDUT] = '{1, 3, 1};

  // reference model state: dead cycles left, prescale count, next tag, drops, FIFO contents
  int          m_dead[NDUT];
  int          m_ps  [NDUT];
  int          m_tag [NDUT];
  int          m_drop[NDUT];
  int          m_cnt [NDUT];
  logic [31:0] m_mem [NDUT][DEPTH];

  int n_chk  = 0;
  int n_pass = 0;

  l1_accept_buffer #(.DEADTIME(4), .PRESCALE(1), .DEPTH(8)) u_dut0 (
    .clk(clk), .rst(rst), .trigger(trigger), .energy(energy), .isol(isol),
    .out_valid(ov[0]), .out_ready(out_ready), .out_tag(otag[0]), .out_energy(oen[0]),
    .out_isol(oiso[0]), .busy(bsy[0]), .drop_count(odrop[0]));

  l1_accept_buffer #(.DEADTIME(0), .PRESCALE(3), .DEPTH(8)) u_dut1 (
    .clk(clk), .rst(rst), .trigger(trigger), .energy(energy), .isol(isol),
    .out_valid(ov[1]), .out_ready(out_ready), .out_tag(otag[1]), .out_energy(oen[1]),
    .out_isol(oiso[1]), .busy(bsy[1]), .drop_count(odrop[1]));

  l1_accept_buffer #(.DEADTIME(0), .PRESCALE(1), .DEPTH(8)) u_dut2 (
    .clk(clk), .rst(rst), .trigger(trigger), .energy(energy), .isol(isol),
    .out_valid(ov[2]), .out_ready(out_ready), .out_tag(otag[2]), .out_energy(oen[2]),
    .out_isol(oiso[2]), .busy(bsy[2]), .drop_count(odrop[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      m_dead[k] = 0; m_ps[k] = 0; m_tag[k] = 0; m_drop[k] = 0; m_cnt[k] = 0;
    end
  endtask

  // one clock edge of the behavioural model for instance k
  task automatic model_edge(input int k, input logic t, input logic [7:0] e,
                            input logic [7:0] s, input logic r);
    logic elig;
    logic acc;
    acc  = 1'b0;
    elig = t && (m_dead[k] == 0);
    if (m_cnt[k] > 0 && r) begin
      for (int j = 0; j < DEPTH - 1; j++) m_mem[k][j] = m_mem[k][j+1];
      m_cnt[k]--;
    end
    if (m_dead[k] > 0) m_dead[k]--;
    if (elig) begin
      m_ps[k]++;
      if (m_ps[k] == ps_of[k]) begin
        m_ps[k] = 0;
        acc = 1'b1;
      end
    end
    if (acc) begin
      if (m_cnt[k] < DEPTH) begin
        m_mem[k][m_cnt[k]] = {16'(m_tag[k]), e, s};
        m_cnt[k]++;
      end else if (m_drop[k] < 65535) begin
        m_drop[k]++;
      end
      m_tag[k]  = (m_tag[k] + 1) % 65536;
      m_dead[k] = dt_of[k];
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("valid%0d", k), 32'(ov[k]), 32'(m_cnt[k] > 0));
      check($sformatf("busy%0d", k), 32'(bsy[k]), 32'(m_dead[k] > 0));
      check($sformatf("drop%0d", k), 32'(odrop[k]), 32'(m_drop[k]));
      if (m_cnt[k] > 0)
        check($sformatf("head%0d", k), {otag[k], oen[k], oiso[k]}, m_mem[k][0]);
    end
  endtask

  task automatic step(input logic t, input logic [7:0] e, input logic [7:0] s, input logic r);
    trigger = t; energy = e; isol = s; out_ready = r;
    #1;
    check_all();
    @(posedge clk);
    for (int k = 0; k < NDUT; k++) model_edge(k, t, e, s, r);
    #1;
  endtask

  task automatic phase(input int cycles, input int trig_pct, input int rdy_pct);
    for (int c = 0; c < cycles; c++)
      step(($urandom_range(99) < trig_pct), 8'($urandom), 8'($urandom),
           ($urandom_range(99) < rdy_pct));
  endtask

  initial begin
    rst = 1'b1; trigger = 1'b0; energy = '0; isol = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("rst_valid%0d", k), 32'(ov[k]), 32'd0);
      check($sformatf("rst_busy%0d", k), 32'(bsy[k]), 32'd0);
    end
    rst = 1'b0;

    step(1'b0, 8'h00, 8'h00, 1'b1);
    step(1'b1, 8'h5A, 8'hF3, 1'b1);
    phase(6, 0, 100);
    phase(12, 100, 100);
    phase(40, 50, 50);
    phase(30, 100, 0);
    phase(20, 0, 100);
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 8'($urandom), 8'($urandom), 1'b0);
      step(1'b0, 8'h00, 8'h00, 1'b0);
    end
    phase(10, 100, 0);
    step(1'b1, 8'h11, 8'h22, 1'b1);
    phase(60, 30, 80);
    phase(40, 100, 100);

    // asynchronous reset between edges with events buffered
    phase(10, 100, 0);
    rst = 1'b1;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("mid_rst_valid%0d", k), 32'(ov[k]), 32'd0);
      check($sformatf("mid_rst_busy%0d", k), 32'(bsy[k]), 32'd0);
      check($sformatf("mid_rst_drop%0d", k), 32'(odrop[k]), 32'd0);
      check($sformatf("mid_rst_head%0d", k), {otag[k], oen[k], oiso[k]}, 32'd0);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    phase(60, 60, 40);
    phase(30, 100, 0);
    phase(30, 20, 100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
